// File: rtl/jk_drive_seq.sv
// Command sequencer producing single-cycle j/k drive pulses for a bank of JK flip-flops.
// Optional predicted-q shadow register enabled by defining JKDRV_SHADOW_EN.
module jk_drive_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_abort,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             aborted
`ifdef JKDRV_SHADOW_EN
  ,
  output logic [WIDTH-1:0] q_shadow
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] OP_TOGGLE = 2'b11;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] j_q, k_q;
  logic             ready_q, busy_q, done_q, aborted_q;

  // Pulse outputs (j, k, done, aborted) default to 0 every edge and are only
  // raised by the transition that needs them, so every output stays registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      mask_q    <= '0;
      rem_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side below reads the value from before this edge.
      j_q       <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && ready_q) begin
            op_q    <= cmd_op;
            mask_q  <= cmd_mask;
            rem_q   <= (cmd_op == OP_TOGGLE && cmd_count != '0) ? cmd_count : CNT_W'(1);
            j_q     <= cmd_mask & {WIDTH{cmd_op[1]}};
            k_q     <= cmd_mask & {WIDTH{cmd_op[0]}};
            state_q <= DRIVE;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DRIVE: begin
          rem_q <= rem_q - CNT_W'(1);
          // The pulse for this cycle is already on j/k, so abort only stops what follows.
          if (cmd_abort || rem_q == CNT_W'(1)) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= cmd_abort;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (cmd_abort) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else begin
            j_q     <= mask_q & {WIDTH{op_q[1]}};
            k_q     <= mask_q & {WIDTH{op_q[0]}};
            state_q <= DRIVE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

`ifdef JKDRV_SHADOW_EN
  logic [WIDTH-1:0] q_shadow_q, q_shadow_d;

  // j/k are zero outside DRIVE cycles, so evaluating every edge only changes q after a pulse.
  always_comb q_shadow_d = (j_q & ~q_shadow_q) | (~k_q & q_shadow_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_shadow_q <= '0;
    else        q_shadow_q <= q_shadow_d;
  end

  assign q_shadow = q_shadow_q;
`endif

endmodule

// File: tb/tb_jk_drive_seq.sv
// Directed self-checking bench for jk_drive_seq; shadow checks compile only with JKDRV_SHADOW_EN.
module tb_jk_drive_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_mask;
  logic [7:0] cmd_count;
  logic       cmd_abort;
  logic [7:0] j, k;
  logic       busy, done, aborted;
`ifdef JKDRV_SHADOW_EN
  logic [7:0] q_shadow;
`endif

  int checks   = 0;
  int failures = 0;

  jk_drive_seq #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_count (cmd_count),
    .cmd_abort (cmd_abort),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
`ifdef JKDRV_SHADOW_EN
    ,
    .q_shadow  (q_shadow)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait_ready got=%b exp=1", tag, cmd_ready);
    end
  endtask

  // Present one command for a single accepting edge; returns in cycle T+1.
  task automatic send(input logic [1:0] op, input logic [7:0] mask, input logic [7:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_count = cnt;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (j !== 8'h00 || k !== 8'h00) begin failures++; $display("FAIL rst_jk got=%h/%h exp=00/00", j, k); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", busy, done, aborted); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
`ifdef JKDRV_SHADOW_EN
    checks++; if (q_shadow !== 8'h00) begin failures++; $display("FAIL rst_shadow got=%h exp=00", q_shadow); end
`endif
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL rel_ready_done got=%b%b exp=10", cmd_ready, done); end

    // Reset in the middle of a toggle burst
    wait_ready("midrst");
    send(2'b11, 8'hFF, 8'd5);
    tick();
    tick();
    checks++; if (busy !== 1'b1 || j !== 8'hFF) begin failures++; $display("FAIL midrst_pre got busy=%b j=%h exp busy=1 j=ff", busy, j); end
    rst_n = 1'b0;
    #1;
    checks++; if (j !== 8'h00 || k !== 8'h00) begin failures++; $display("FAIL midrst_jk got=%h/%h exp=00/00", j, k); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin failures++; $display("FAIL midrst_flags got busy=%b done=%b ready=%b exp=000", busy, done, cmd_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL midrst_rel got ready=%b done=%b exp=1/0", cmd_ready, done); end
    tick();
    checks++; if (done !== 1'b0 || j !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL midrst_quiet got done=%b j=%h busy=%b exp=0/00/0", done, j, busy); end
  endtask

  task automatic test_set();
    wait_ready("set");
    send(2'b10, 8'hA5, 8'd0);
    checks++; if (j !== 8'hA5 || k !== 8'h00) begin failures++; $display("FAIL set_drive got=%h/%h exp=a5/00", j, k); end
    checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL set_busy got busy=%b ready=%b done=%b exp=1/0/0", busy, cmd_ready, done); end
    tick();
    checks++; if (j !== 8'h00 || k !== 8'h00) begin failures++; $display("FAIL set_after got=%h/%h exp=00/00", j, k); end
    checks++; if (done !== 1'b1 || aborted !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL set_done got done=%b aborted=%b ready=%b exp=1/0/1", done, aborted, cmd_ready); end
`ifdef JKDRV_SHADOW_EN
    checks++; if (q_shadow !== 8'hA5) begin failures++; $display("FAIL set_shadow got=%h exp=a5", q_shadow); end
`endif
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL set_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_clear();
    wait_ready("clr");
    send(2'b01, 8'hFF, 8'd7);
    checks++; if (j !== 8'h00 || k !== 8'hFF) begin failures++; $display("FAIL clr_drive got=%h/%h exp=00/ff", j, k); end
    tick();
    checks++; if (done !== 1'b1 || k !== 8'h00) begin failures++; $display("FAIL clr_done got done=%b k=%h exp=1/00", done, k); end
`ifdef JKDRV_SHADOW_EN
    checks++; if (q_shadow !== 8'h00) begin failures++; $display("FAIL clr_shadow got=%h exp=00", q_shadow); end
`endif
  endtask

  task automatic test_toggle_burst();
    logic [7:0] exp_jk;
    wait_ready("tog");
    send(2'b11, 8'h0F, 8'd3);
    for (int c = 1; c <= 6; c++) begin
      exp_jk = (c % 2 == 1) ? 8'h0F : 8'h00;
      checks++; if (j !== exp_jk || k !== exp_jk) begin failures++; $display("FAIL tog_jk_c%0d got=%h/%h exp=%h/%h", c, j, k, exp_jk, exp_jk); end
      checks++; if (done !== (c == 6)) begin failures++; $display("FAIL tog_done_c%0d got=%b exp=%b", c, done, (c == 6)); end
      if (c < 6) tick();
    end
    checks++; if (aborted !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL tog_end got aborted=%b ready=%b exp=0/1", aborted, cmd_ready); end
`ifdef JKDRV_SHADOW_EN
    checks++; if (q_shadow !== 8'h0F) begin failures++; $display("FAIL tog_shadow got=%h exp=0f", q_shadow); end
`endif
  endtask

  task automatic test_count_zero();
    wait_ready("cnt0");
    send(2'b11, 8'h3C, 8'd0);
    checks++; if (j !== 8'h3C || k !== 8'h3C) begin failures++; $display("FAIL cnt0_drive got=%h/%h exp=3c/3c", j, k); end
    tick();
    checks++; if (done !== 1'b1 || j !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL cnt0_done got done=%b j=%h busy=%b exp=1/00/0", done, j, busy); end
`ifdef JKDRV_SHADOW_EN
    checks++; if (q_shadow !== 8'h33) begin failures++; $display("FAIL cnt0_shadow got=%h exp=33", q_shadow); end
`endif
  endtask

  task automatic test_abort();
    int pulses;
    // Abort while idle must be ignored
    wait_ready("abidle");
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    checks++; if (done !== 1'b0 || aborted !== 1'b0) begin failures++; $display("FAIL abort_idle got done=%b aborted=%b exp=0/0", done, aborted); end

    pulses = 0;
    send(2'b11, 8'hFF, 8'd5);
    for (int c = 1; c <= 4; c++) begin
      if (j !== 8'h00) pulses++;
      if (c == 4) cmd_abort = 1'b1;
      tick();
    end
    cmd_abort = 1'b0;
    checks++; if (pulses != 2) begin failures++; $display("FAIL abort_pulses got=%0d exp=2", pulses); end
    checks++; if (done !== 1'b1 || aborted !== 1'b1 || cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_done got done=%b aborted=%b ready=%b exp=1/1/1", done, aborted, cmd_ready); end
    checks++; if (j !== 8'h00 || k !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL abort_jk got=%h/%h busy=%b exp=00/00/0", j, k, busy); end
`ifdef JKDRV_SHADOW_EN
    checks++; if (q_shadow !== 8'h33) begin failures++; $display("FAIL abort_shadow got=%h exp=33", q_shadow); end
`endif
    tick();
    checks++; if (done !== 1'b0 || aborted !== 1'b0) begin failures++; $display("FAIL abort_pulse got done=%b aborted=%b exp=0/0", done, aborted); end
  endtask

  task automatic test_back_to_back();
    wait_ready("b2b");
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_mask  = 8'h55;
    cmd_count = 8'd0;
    tick();
    checks++; if (j !== 8'h00 || k !== 8'h00 || busy !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_hold got=%h/%h busy=%b ready=%b exp=00/00/1/0", j, k, busy, cmd_ready); end
    cmd_op   = 2'b01;
    cmd_mask = 8'hC3;
    tick();
    checks++; if (done !== 1'b1 || aborted !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_done1 got done=%b aborted=%b ready=%b exp=1/0/1", done, aborted, cmd_ready); end
    checks++; if (j !== 8'h00 || k !== 8'h00) begin failures++; $display("FAIL b2b_gap got=%h/%h exp=00/00", j, k); end
    tick();
    cmd_valid = 1'b0;
    checks++; if (j !== 8'h00 || k !== 8'hC3 || done !== 1'b0) begin failures++; $display("FAIL b2b_clear got=%h/%h done=%b exp=00/c3/0", j, k, done); end
    tick();
    checks++; if (done !== 1'b1 || k !== 8'h00) begin failures++; $display("FAIL b2b_done2 got done=%b k=%h exp=1/00", done, k); end
`ifdef JKDRV_SHADOW_EN
    checks++; if (q_shadow !== 8'h30) begin failures++; $display("FAIL b2b_shadow got=%h exp=30", q_shadow); end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_mask  = 8'h00;
    cmd_count = 8'd0;
    cmd_abort = 1'b0;
    test_reset();
    test_set();
    test_clear();
    test_toggle_burst();
    test_count_zero();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
